// File: rtl/dbus_turnaround_pkg.sv
// Shared definitions for the cartridge data-bus transceiver sequencers:
// state encodings, counter widths and default guard timings.
package dbus_turnaround_pkg;

    localparam int TURN_CNT_W = 16;
    localparam int CNT_W      = 4;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_GUARD_OFF   = 2;
    localparam int DEF_GUARD_DIR   = 1;
    localparam int DEF_MIN_OUT     = 3;

    typedef enum logic [2:0] {
        ST_IN    = 3'd0,
        ST_OFF_O = 3'd1,
        ST_DIR_O = 3'd2,
        ST_OUT   = 3'd3,
        ST_OFF_I = 3'd4,
        ST_DIR_I = 3'd5
    } state_t;

    // Pin levels owned by each state, packed as {dat_dir, dat_oe, busy}.
    function automatic logic [2:0] state_outputs(input state_t s);
        logic [2:0] o;
        o = 3'b000;
        case (s)
            ST_IN:    o = 3'b000;
            ST_OFF_O: o = 3'b011;
            ST_DIR_O: o = 3'b111;
            ST_OUT:   o = 3'b100;
            ST_OFF_I: o = 3'b111;
            ST_DIR_I: o = 3'b011;
            default:  o = 3'b000;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/dbus_turnaround_sync_ff.sv
// Multi-stage single-bit synchroniser with synchronous clear.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic src;
            if (gi == 0) begin : g_first
                assign src = d;
            end else begin : g_chain
                assign src = stage_reg[gi-1];
            end

            always_ff @(posedge clk) begin
                if (srst) begin
                    stage_reg[gi] <= 1'b0;
                end else begin
                    stage_reg[gi] <= src;
                end
            end
        end
    endgenerate

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/dbus_turnaround.sv
// Data-bus transceiver turnaround sequencer: turns a raw drive request into
// dat_dir/dat_oe with dead time on both sides of every direction flip.
module dbus_turnaround
    import dbus_turnaround_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int GUARD_OFF   = DEF_GUARD_OFF,
    parameter int GUARD_DIR   = DEF_GUARD_DIR,
    parameter int MIN_OUT     = DEF_MIN_OUT
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic                  bus_oe,
    output logic                  dat_dir,
    output logic                  dat_oe,
    output logic                  busy,
    output logic                  short_req,
    output logic [TURN_CNT_W-1:0] turn_cnt
);

    generate
        if (SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : g_bad_sync
            $error("dbus_turnaround: SYNC_STAGES must be 1..3");
        end
        if (GUARD_OFF < 1 || GUARD_OFF > 15 || GUARD_DIR < 1 || GUARD_DIR > 15
            || MIN_OUT < 1 || MIN_OUT > 15) begin : g_bad_guard
            $error("dbus_turnaround: guard/hold parameters must be 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(GUARD_OFF - 1);
    localparam logic [CNT_W-1:0] DIR_LOAD = CNT_W'(GUARD_DIR - 1);
    localparam logic [CNT_W-1:0] OUT_LOAD = CNT_W'(MIN_OUT - 1);

    logic req;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .srst (sys_rst),
        .d    (bus_oe),
        .q    (req)
    );

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic                    short_req_reg, short_req_next;
    logic [TURN_CNT_W-1:0]   turn_cnt_reg, turn_cnt_next;
    logic                    dat_dir_reg, dat_oe_reg, busy_reg;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        short_req_next = short_req_reg;
        turn_cnt_next  = turn_cnt_reg;
        case (state_reg)
            ST_IN: begin
                if (req) begin
                    state_next = ST_OFF_O;
                    cnt_next   = OFF_LOAD;
                end
            end
            ST_OFF_O: begin
                if (!req) begin
                    state_next     = ST_IN;
                    short_req_next = 1'b1;
                end else if (cnt_reg == '0) begin
                    state_next = ST_DIR_O;
                    cnt_next   = DIR_LOAD;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_DIR_O: begin
                // An abort here leaves via ST_DIR_I so the direction flips back
                // while the transceiver is still disabled.
                if (!req) begin
                    state_next     = ST_DIR_I;
                    cnt_next       = DIR_LOAD;
                    short_req_next = 1'b1;
                end else if (cnt_reg == '0) begin
                    state_next = ST_OUT;
                    cnt_next   = OUT_LOAD;
                    if (turn_cnt_reg != '1) begin
                        turn_cnt_next = turn_cnt_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_OUT: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else if (!req) begin
                    state_next = ST_OFF_I;
                    cnt_next   = OFF_LOAD;
                end
            end
            ST_OFF_I: begin
                if (cnt_reg == '0) begin
                    state_next = ST_DIR_I;
                    cnt_next   = DIR_LOAD;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_DIR_I: begin
                if (cnt_reg == '0) begin
                    state_next = ST_IN;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = ST_IN;
                cnt_next   = '0;
            end
        endcase
    end

    // Output flops load from the next state so pins and state stay aligned.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_reg     <= ST_IN;
            cnt_reg       <= '0;
            short_req_reg <= 1'b0;
            turn_cnt_reg  <= '0;
            dat_dir_reg   <= 1'b0;
            dat_oe_reg    <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            short_req_reg <= short_req_next;
            turn_cnt_reg  <= turn_cnt_next;
            {dat_dir_reg, dat_oe_reg, busy_reg} <= state_outputs(state_next);
        end
    end

    assign dat_dir   = dat_dir_reg;
    assign dat_oe    = dat_oe_reg;
    assign busy      = busy_reg;
    assign short_req = short_req_reg;
    assign turn_cnt  = turn_cnt_reg;

endmodule

// File: tb/tb_dbus_turnaround.sv
// Scoreboard bench: stimulus queues the expected {dat_dir,dat_oe,busy} changes
// with their cycle numbers; a monitor pops one per observed pin change.
module tb_dbus_turnaround;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        bus_oe, bus_oe2;
    logic        dat_dir, dat_oe, busy, short_req;
    logic [15:0] turn_cnt;
    logic        dat_dir2, dat_oe2, busy2, short_req2;
    logic [15:0] turn_cnt2;

    always #5 clk = ~clk;

    dbus_turnaround u_dut (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .bus_oe    (bus_oe),
        .dat_dir   (dat_dir),
        .dat_oe    (dat_oe),
        .busy      (busy),
        .short_req (short_req),
        .turn_cnt  (turn_cnt)
    );

    dbus_turnaround #(.GUARD_OFF(1), .GUARD_DIR(3)) u_dut2 (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .bus_oe    (bus_oe2),
        .dat_dir   (dat_dir2),
        .dat_oe    (dat_oe2),
        .busy      (busy2),
        .short_req (short_req2),
        .turn_cnt  (turn_cnt2)
    );

    typedef struct {
        int   cyc;
        logic dir;
        logic oe;
        logic busy;
    } ev_t;

    ev_t q1[$];
    ev_t q2[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp1(input int c, input logic d, input logic o);
        q1.push_back('{c, d, o, o});
    endtask

    task automatic exp2(input int c, input logic d, input logic o);
        q2.push_back('{c, d, o, o});
    endtask

    // Default-parameter out-sequence / release-sequence starting at drive cycle t.
    task automatic full_out(input int t);
        exp1(t + 3, 1'b0, 1'b1);
        exp1(t + 5, 1'b1, 1'b1);
        exp1(t + 6, 1'b1, 1'b0);
    endtask

    task automatic release_seq(input int t);
        exp1(t + 3, 1'b1, 1'b1);
        exp1(t + 5, 1'b0, 1'b1);
        exp1(t + 6, 1'b0, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic compare_ev(input string nm, input ev_t e, input logic [2:0] cur);
        checks++;
        if (e.cyc != cyc || cur !== {e.dir, e.oe, e.busy}) begin
            errors++;
            $display("FAIL %s: got dir/oe/busy %b at cycle %0d, want %b at cycle %0d",
                     nm, cur, cyc, {e.dir, e.oe, e.busy}, e.cyc);
        end
    endtask

    logic [2:0] prev1 = 3'b000;
    logic [2:0] prev2 = 3'b000;
    logic [2:0] cur1, cur2;
    ev_t        e;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            cur1 = {dat_dir, dat_oe, busy};
            while (q1.size() > 0 && q1[0].cyc < cyc) begin
                e = q1.pop_front();
                checks++;
                errors++;
                $display("FAIL dut1_missed: change to %b due at cycle %0d never seen", {e.dir, e.oe, e.busy}, e.cyc);
            end
            if (cur1 !== prev1) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut1_unexpected: got change %b -> %b at cycle %0d, want no change", prev1, cur1, cyc);
                end else begin
                    e = q1.pop_front();
                    compare_ev("dut1_event", e, cur1);
                end
            end
            prev1 = cur1;

            cur2 = {dat_dir2, dat_oe2, busy2};
            while (q2.size() > 0 && q2[0].cyc < cyc) begin
                e = q2.pop_front();
                checks++;
                errors++;
                $display("FAIL dut2_missed: change to %b due at cycle %0d never seen", {e.dir, e.oe, e.busy}, e.cyc);
            end
            if (cur2 !== prev2) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut2_unexpected: got change %b -> %b at cycle %0d, want no change", prev2, cur2, cyc);
                end else begin
                    e = q2.pop_front();
                    compare_ev("dut2_event", e, cur2);
                end
            end
            prev2 = cur2;
        end
    end

    int t0, t1;

    initial begin
        sys_rst = 1'b1;
        bus_oe  = 1'b1;
        bus_oe2 = 1'b0;

        // Reset with the request already high, then the full default turnaround.
        tick(3);
        chk("reset_dat_dir", {15'd0, dat_dir}, 16'd0);
        chk("reset_dat_oe", {15'd0, dat_oe}, 16'd0);
        chk("reset_busy", {15'd0, busy}, 16'd0);
        chk("reset_short_req", {15'd0, short_req}, 16'd0);
        chk("reset_turn_cnt", turn_cnt, 16'd0);
        sys_rst = 1'b0;
        t0 = cyc;
        full_out(t0);
        tick(20);
        chk("turn_after_first", turn_cnt, 16'd1);
        chk("busy_in_out", {15'd0, busy}, 16'd0);
        bus_oe = 1'b0;
        release_seq(cyc);
        tick(12);

        // Request drops immediately after reaching ST_OUT: MIN_OUT hold.
        t0 = cyc;
        bus_oe = 1'b1;
        exp1(t0 + 3, 1'b0, 1'b1);
        exp1(t0 + 5, 1'b1, 1'b1);
        exp1(t0 + 6, 1'b1, 1'b0);
        exp1(t0 + 9, 1'b1, 1'b1);
        exp1(t0 + 11, 1'b0, 1'b1);
        exp1(t0 + 12, 1'b0, 1'b0);
        tick(4);
        bus_oe = 1'b0;
        tick(12);
        chk("turn_after_min_out", turn_cnt, 16'd2);
        chk("short_after_min_out", {15'd0, short_req}, 16'd0);

        // One-cycle request aborts from ST_OFF_O.
        t0 = cyc;
        bus_oe = 1'b1;
        exp1(t0 + 3, 1'b0, 1'b1);
        exp1(t0 + 4, 1'b0, 1'b0);
        tick(1);
        bus_oe = 1'b0;
        tick(8);
        chk("short_req_set", {15'd0, short_req}, 16'd1);
        chk("turn_after_short", turn_cnt, 16'd2);

        // Second instance (GUARD_OFF=1, GUARD_DIR=3): abort from ST_DIR_O.
        t0 = cyc;
        bus_oe2 = 1'b1;
        exp2(t0 + 3, 1'b0, 1'b1);
        exp2(t0 + 4, 1'b1, 1'b1);
        exp2(t0 + 5, 1'b0, 1'b1);
        exp2(t0 + 8, 1'b0, 1'b0);
        tick(2);
        bus_oe2 = 1'b0;
        tick(10);
        chk("dut2_short_req", {15'd0, short_req2}, 16'd1);
        chk("dut2_turn_after_abort", turn_cnt2, 16'd0);

        // Second instance full turnaround with its own guard timing.
        t0 = cyc;
        bus_oe2 = 1'b1;
        exp2(t0 + 3, 1'b0, 1'b1);
        exp2(t0 + 4, 1'b1, 1'b1);
        exp2(t0 + 7, 1'b1, 1'b0);
        tick(12);
        t1 = cyc;
        bus_oe2 = 1'b0;
        exp2(t1 + 3, 1'b1, 1'b1);
        exp2(t1 + 4, 1'b0, 1'b1);
        exp2(t1 + 7, 1'b0, 1'b0);
        tick(12);
        chk("dut2_turn_full", turn_cnt2, 16'd1);

        // Re-request during the release: release completes, then a new out-sequence.
        t0 = cyc;
        bus_oe = 1'b1;
        full_out(t0);
        tick(10);
        t1 = cyc;
        bus_oe = 1'b0;
        release_seq(t1);
        tick(2);
        bus_oe = 1'b1;
        full_out(t1 + 4);
        tick(18);
        bus_oe = 1'b0;
        release_seq(cyc);
        tick(10);
        chk("turn_after_rerequest", turn_cnt, 16'd4);

        // Saturation: preload near the top, then two more turnarounds.
        force u_dut.turn_cnt_reg = 16'hFFFE;
        tick(1);
        release u_dut.turn_cnt_reg;
        tick(1);
        chk("turn_preload", turn_cnt, 16'hFFFE);
        for (int k = 0; k < 2; k++) begin
            bus_oe = 1'b1;
            full_out(cyc);
            tick(10);
            bus_oe = 1'b0;
            release_seq(cyc);
            tick(10);
            chk("turn_saturated", turn_cnt, 16'hFFFF);
        end

        // Reset while in ST_OFF_I.
        bus_oe = 1'b1;
        full_out(cyc);
        tick(10);
        t1 = cyc;
        bus_oe = 1'b0;
        exp1(t1 + 3, 1'b1, 1'b1);
        exp1(t1 + 4, 1'b0, 1'b0);
        tick(3);
        sys_rst = 1'b1;
        tick(1);
        sys_rst = 1'b0;
        chk("midrst_dat_dir", {15'd0, dat_dir}, 16'd0);
        chk("midrst_dat_oe", {15'd0, dat_oe}, 16'd0);
        chk("midrst_turn_cnt", turn_cnt, 16'd0);
        chk("midrst_short_req", {15'd0, short_req}, 16'd0);
        tick(6);

        chk("dut1_queue_left", 16'(q1.size()), 16'd0);
        chk("dut2_queue_left", 16'(q2.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
